// File: rtl/load_store_unit.sv
// load_store_unit
// Sits behind the ALU: uses the ALU result as an effective byte address and rs2
// as store data. It runs one access at a time on a word-wide req/ack memory bus,
// steers byte/half/word lanes, and sign- or zero-extends load results. While an
// access is outstanding it holds the core with stall.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   mem_read, mem_write access request from the control unit (write wins if both)
//   funct3              access size/sign (instruction[14:12])
//   addr, store_data    effective byte address, rs2 value
//   load_data           extended load result to the write-back mux
//   stall               hold PC/pipeline this cycle
//   misaligned          combinational alignment fault, valid in IDLE only
//   bus_err             one-cycle pulse when an access is aborted on timeout
//   bus_req/we/addr/wdata/wstrb   memory request, held stable while BUSY
//   bus_ack, bus_rdata  memory completion and read word
//
// state | meaning
// IDLE  | waiting for an aligned access; stall raised combinationally on request
// BUSY  | bus_req high, waiting for bus_ack or timeout
// DONE  | access finished, stall low so the PC advances; back to IDLE next edge
module load_store_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic        stall,
   output logic        misaligned,
   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

   state_t      state_q, state_d;
   logic [31:0] load_data_q, load_data_d;
   logic        bus_err_q, bus_err_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [3:0]  bus_wstrb_q, bus_wstrb_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  offset_q, offset_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        access;
   logic        fault;
   logic [31:0] wdata_lane;
   logic [3:0]  wstrb_lane;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] rd_ext;
   logic [7:0]  cnt_inc;
   logic        timeout_hit;

   // Alignment fault and request decode
   always_comb begin
      access = mem_read | mem_write;
      fault  = 1'b0;
      case (funct3[1:0])
         2'b00:   fault = 1'b0;
         2'b01:   fault = addr[0];
         default: fault = addr[1] | addr[0];
      endcase
   end

   assign misaligned = access & fault & (state_q == S_IDLE);

   // Stall covers the request cycle in IDLE plus every BUSY cycle, but never
   // while reset is held so the core is not frozen during reset.
   assign stall = ~reset &
                  (((state_q == S_IDLE) & access & ~fault) | (state_q == S_BUSY));

   // Store lane replication and byte enables
   always_comb begin
      wdata_lane = store_data;
      wstrb_lane = 4'b1111;
      case (funct3[1:0])
         2'b00: begin
            wdata_lane = {4{store_data[7:0]}};
            wstrb_lane = 4'b0001 << addr[1:0];
         end
         2'b01: begin
            wdata_lane = {2{store_data[15:0]}};
            wstrb_lane = addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wdata_lane = store_data;
            wstrb_lane = 4'b1111;
         end
      endcase
   end

   // Load lane extraction uses the offset latched at request time, since the
   // core may already be presenting different inputs by the time ack arrives.
   always_comb begin
      rd_byte = bus_rdata[7:0];
      case (offset_q)
         2'd0: rd_byte = bus_rdata[7:0];
         2'd1: rd_byte = bus_rdata[15:8];
         2'd2: rd_byte = bus_rdata[23:16];
         default: rd_byte = bus_rdata[31:24];
      endcase
      rd_half = offset_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (funct3_q)
         3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
         3'b100:  rd_ext = {24'd0, rd_byte};
         3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
         3'b101:  rd_ext = {16'd0, rd_half};
         default: rd_ext = bus_rdata;
      endcase
   end

   assign cnt_inc     = cnt_q + 8'd1;
   assign timeout_hit = (cnt_inc == TIMEOUT_L);

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      load_data_d = load_data_q;
      bus_err_d   = 1'b0;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_wstrb_d = bus_wstrb_q;
      funct3_d    = funct3_q;
      offset_d    = offset_q;
      cnt_d       = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (access && !fault) begin
               state_d     = S_BUSY;
               bus_req_d   = 1'b1;
               bus_we_d    = mem_write;
               bus_addr_d  = {addr[31:2], 2'b00};
               bus_wdata_d = mem_write ? wdata_lane : 32'd0;
               bus_wstrb_d = mem_write ? wstrb_lane : 4'd0;
               funct3_d    = funct3;
               offset_d    = addr[1:0];
               cnt_d       = 8'd0;
            end
         end
         S_BUSY: begin
            cnt_d = cnt_inc;
            // A late ack on the timeout cycle still completes the access.
            if (bus_ack) begin
               bus_req_d = 1'b0;
               if (!bus_we_q) begin
                  load_data_d = rd_ext;
               end
               state_d = S_DONE;
            end else if (timeout_hit) begin
               bus_req_d   = 1'b0;
               load_data_d = 32'd0;
               bus_err_d   = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d   = S_IDLE;
            bus_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         load_data_q <= 32'd0;
         bus_err_q   <= 1'b0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'd0;
         bus_wdata_q <= 32'd0;
         bus_wstrb_q <= 4'd0;
         funct3_q    <= 3'd0;
         offset_q    <= 2'd0;
         cnt_q       <= 8'd0;
      end else begin
         state_q     <= state_d;
         load_data_q <= load_data_d;
         bus_err_q   <= bus_err_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_wstrb_q <= bus_wstrb_d;
         funct3_q    <= funct3_d;
         offset_q    <= offset_d;
         cnt_q       <= cnt_d;
      end
   end

   assign load_data = load_data_q;
   assign bus_err   = bus_err_q;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_wstrb = bus_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit with TIMEOUT=4: directed scenarios plus a random
// run checked against a byte-arithmetic model of the lane and timeout rules.
module tb_load_store_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read, mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data;
   logic [31:0] load_data;
   logic        stall, misaligned, bus_err, bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int errors = 0;
   int checks = 0;
   logic [31:0] ld_model;

   // observations collected by run_access
   logic        o_mis, o_stall0, o_req_after_mis, o_stall_after_mis;
   int          o_req_cycles, o_stall_cycles;
   logic [31:0] o_addr, o_wdata, o_ld;
   logic        o_we, o_unstable, o_done_stall, o_err_done, o_err_after, o_req_idle, o_hung;
   logic [3:0]  o_wstrb;

   load_store_unit #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
      .funct3(funct3), .addr(addr), .store_data(store_data), .load_data(load_data),
      .stall(stall), .misaligned(misaligned), .bus_err(bus_err), .bus_req(bus_req),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
      int size;
      size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      return (a % size) != 0;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] rd);
      logic [31:0] b, h;
      b = (rd >> (8 * (a % 4))) & 32'hff;
      h = (rd >> (16 * ((a % 4) / 2))) & 32'hffff;
      case (f3)
         3'd0: return (b >= 32'd128) ? (b | 32'hffffff00) : b;
         3'd4: return b;
         3'd1: return (h >= 32'h8000) ? (h | 32'hffff0000) : h;
         3'd5: return h;
         default: return rd;
      endcase
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
      if (f3[1:0] == 2'b00) return (sd & 32'hff) * 32'h01010101;
      if (f3[1:0] == 2'b01) return (sd & 32'hffff) * 32'h00010001;
      return sd;
   endfunction

   function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] a);
      if (f3[1:0] == 2'b00) return 4'(1 << (a % 4));
      if (f3[1:0] == 2'b01) return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
      return 4'b1111;
   endfunction

   // ---------------- stimulus driver (no checks) ----------------
   // Entered #1 after a rising edge with the DUT in IDLE; returns in the same phase.
   // ack_at = BUSY cycle (1-based) on which bus_ack is driven; 0 = never.
   task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] sd,
                             input int ack_at, input logic [31:0] rdata);
      int k;
      mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
      bus_ack = 1'b0; bus_rdata = rdata;
      o_req_cycles = 0; o_unstable = 1'b0; o_hung = 1'b0;
      #1;
      o_mis = misaligned; o_stall0 = stall; o_stall_cycles = stall ? 1 : 0;
      if (o_mis) begin
         @(posedge clk); #1;
         o_req_after_mis = bus_req; o_stall_after_mis = stall;
         mem_read = 1'b0; mem_write = 1'b0;
         return;
      end
      @(posedge clk); #1;
      o_addr = bus_addr; o_we = bus_we; o_wdata = bus_wdata; o_wstrb = bus_wstrb;
      k = 0;
      while (bus_req && k < 300) begin
         k++;
         o_req_cycles++;
         if (stall) o_stall_cycles++;
         if (bus_addr !== o_addr || bus_we !== o_we || bus_wdata !== o_wdata ||
             bus_wstrb !== o_wstrb) o_unstable = 1'b1;
         bus_ack = (k == ack_at);
         @(posedge clk); #1;
         bus_ack = 1'b0;
      end
      o_hung = (k >= 300);
      o_done_stall = stall; o_ld = load_data; o_err_done = bus_err;
      @(posedge clk); #1;
      o_err_after = bus_err; o_req_idle = bus_req;
      mem_read = 1'b0; mem_write = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'd2; addr = 32'h10;
      store_data = 0; bus_ack = 0; bus_rdata = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", bus_req); end
      checks++; if (load_data !== 32'd0) begin errors++; $display("FAIL reset_ld got=%h exp=0", load_data); end
      checks++; if ({bus_err, bus_we, bus_wstrb} !== 6'd0 || bus_addr !== 0 || bus_wdata !== 0) begin
         errors++; $display("FAIL reset_bus err=%b we=%b strb=%b addr=%h wd=%h exp=all 0",
                             bus_err, bus_we, bus_wstrb, bus_addr, bus_wdata); end
      mem_read = 1'b0;
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      ld_model = 32'd0;
   endtask

   task automatic test_lw();
      run_access(1, 0, 3'd2, 32'h10, 0, 2, 32'hDEADBEEF);
      checks++; if (o_hung) begin errors++; $display("FAIL lw_hang got=no-done exp=done"); end
      checks++; if (o_addr !== 32'h10 || o_we !== 1'b0 || o_wstrb !== 4'b0000) begin
         errors++; $display("FAIL lw_bus addr=%h we=%b strb=%b exp=00000010/0/0000", o_addr, o_we, o_wstrb); end
      checks++; if (o_stall_cycles != 3) begin errors++; $display("FAIL lw_stall_cycles got=%0d exp=3", o_stall_cycles); end
      checks++; if (o_done_stall !== 1'b0) begin errors++; $display("FAIL lw_done_stall got=%b exp=0", o_done_stall); end
      checks++; if (o_ld !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got=%h exp=deadbeef", o_ld); end
      checks++; if (o_err_done !== 1'b0 || o_req_idle !== 1'b0) begin
         errors++; $display("FAIL lw_tail err=%b req=%b exp=0/0", o_err_done, o_req_idle); end
      ld_model = 32'hDEADBEEF;
   endtask

   task automatic test_load_lanes();
      run_access(1, 0, 3'd0, 32'h13, 0, 1, 32'h80FF7F01);
      checks++; if (o_ld !== 32'hFFFFFF80) begin errors++; $display("FAIL lb got=%h exp=ffffff80", o_ld); end
      run_access(1, 0, 3'd4, 32'h13, 0, 1, 32'h80FF7F01);
      checks++; if (o_ld !== 32'h00000080) begin errors++; $display("FAIL lbu got=%h exp=00000080", o_ld); end
      run_access(1, 0, 3'd5, 32'h12, 0, 1, 32'h80FF7F01);
      checks++; if (o_ld !== 32'h000080FF) begin errors++; $display("FAIL lhu got=%h exp=000080ff", o_ld); end
      run_access(1, 0, 3'd1, 32'h12, 0, 1, 32'h80FF7F01);
      checks++; if (o_ld !== 32'hFFFF80FF) begin errors++; $display("FAIL lh got=%h exp=ffff80ff", o_ld); end
      ld_model = 32'hFFFF80FF;
   endtask

   task automatic test_store();
      run_access(0, 1, 3'd0, 32'h21, 32'h000000AB, 1, 32'h55555555);
      checks++; if (o_we !== 1'b1 || o_wdata !== 32'hABABABAB || o_wstrb !== 4'b0010 || o_addr !== 32'h20) begin
         errors++; $display("FAIL sb we=%b wd=%h strb=%b addr=%h exp=1/abababab/0010/00000020", o_we, o_wdata, o_wstrb, o_addr); end
      checks++; if (o_ld !== ld_model) begin errors++; $display("FAIL sb_ld_kept got=%h exp=%h", o_ld, ld_model); end
      run_access(0, 1, 3'd1, 32'h22, 32'h00001234, 1, 32'h55555555);
      checks++; if (o_we !== 1'b1 || o_wdata !== 32'h12341234 || o_wstrb !== 4'b1100) begin
         errors++; $display("FAIL sh we=%b wd=%h strb=%b exp=1/12341234/1100", o_we, o_wdata, o_wstrb); end
      // both requests set: treated as a write
      run_access(1, 1, 3'd2, 32'h40, 32'hCAFEF00D, 1, 32'h11111111);
      checks++; if (o_we !== 1'b1 || o_wdata !== 32'hCAFEF00D || o_wstrb !== 4'b1111 || o_ld !== ld_model) begin
         errors++; $display("FAIL rw_is_write we=%b wd=%h strb=%b ld=%h exp=1/cafef00d/1111/%h", o_we, o_wdata, o_wstrb, o_ld, ld_model); end
   endtask

   task automatic test_misaligned();
      run_access(1, 0, 3'd2, 32'h06, 0, 1, 32'h12345678);
      checks++; if (o_mis !== 1'b1 || o_stall0 !== 1'b0) begin
         errors++; $display("FAIL lw_mis mis=%b stall=%b exp=1/0", o_mis, o_stall0); end
      checks++; if (o_req_after_mis !== 1'b0 || o_stall_after_mis !== 1'b0 || load_data !== ld_model) begin
         errors++; $display("FAIL lw_mis_idle req=%b stall=%b ld=%h exp=0/0/%h", o_req_after_mis, o_stall_after_mis, load_data, ld_model); end
      run_access(1, 0, 3'd1, 32'h06, 0, 1, 32'h12345678);
      checks++; if (o_mis !== 1'b0 || o_ld !== 32'h00001234) begin
         errors++; $display("FAIL lh_ok mis=%b ld=%h exp=0/00001234", o_mis, o_ld); end
      ld_model = 32'h00001234;
   endtask

   task automatic test_timeout();
      run_access(1, 0, 3'd2, 32'h80, 0, 0, 32'h0);
      checks++; if (o_hung || o_req_cycles != TO) begin
         errors++; $display("FAIL to_req_cycles got=%0d exp=%0d", o_req_cycles, TO); end
      checks++; if (o_err_done !== 1'b1 || o_err_after !== 1'b0) begin
         errors++; $display("FAIL to_err_pulse done=%b next=%b exp=1/0", o_err_done, o_err_after); end
      checks++; if (o_ld !== 32'd0 || o_done_stall !== 1'b0 || o_req_idle !== 1'b0) begin
         errors++; $display("FAIL to_tail ld=%h stall=%b req=%b exp=0/0/0", o_ld, o_done_stall, o_req_idle); end
      run_access(1, 0, 3'd2, 32'h84, 0, TO, 32'hA5A5F00F);
      checks++; if (o_req_cycles != TO || o_err_done !== 1'b0 || o_ld !== 32'hA5A5F00F) begin
         errors++; $display("FAIL to_ack_wins cycles=%0d err=%b ld=%h exp=%0d/0/a5a5f00f", o_req_cycles, o_err_done, o_ld, TO); end
      ld_model = 32'hA5A5F00F;
   endtask

   task automatic test_reset_busy();
      mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'd2; addr = 32'h90; bus_ack = 1'b0;
      @(posedge clk); #1;
      checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rb_busy req=%b exp=1", bus_req); end
      reset = 1'b1;
      #1;
      checks++; if (bus_req !== 1'b0 || stall !== 1'b0 || load_data !== 32'd0) begin
         errors++; $display("FAIL rb_async req=%b stall=%b ld=%h exp=0/0/0", bus_req, stall, load_data); end
      mem_read = 1'b0;
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      run_access(1, 0, 3'd2, 32'h94, 0, 1, 32'h0BADCAFE);
      checks++; if (o_hung || o_addr !== 32'h94 || o_ld !== 32'h0BADCAFE || o_stall_cycles != 2) begin
         errors++; $display("FAIL rb_fresh addr=%h ld=%h stalls=%0d exp=00000094/0badcafe/2", o_addr, o_ld, o_stall_cycles); end
      ld_model = 32'h0BADCAFE;
   endtask

   task automatic test_random();
      logic rd, wr;
      logic [2:0] f3;
      logic [31:0] a, sd, rdv;
      int ack_at;
      for (int i = 0; i < 60; i++) begin
         wr = 1'($urandom_range(0, 1));
         rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         f3 = 3'($urandom_range(0, 7));
         a = $urandom; sd = $urandom; rdv = $urandom;
         ack_at = $urandom_range(1, TO + 1);
         run_access(rd, wr, f3, a, sd, ack_at, rdv);
         checks++;
         if (m_mis(f3, a)) begin
            if (o_mis !== 1'b1 || o_req_after_mis !== 1'b0 || load_data !== ld_model) begin
               errors++; $display("FAIL rnd_mis i=%0d mis=%b req=%b ld=%h exp=1/0/%h", i, o_mis, o_req_after_mis, load_data, ld_model); end
         end else if (ack_at > TO) begin
            ld_model = 32'd0;
            if (o_hung || o_mis !== 1'b0 || o_req_cycles != TO || o_err_done !== 1'b1 || o_ld !== ld_model) begin
               errors++; $display("FAIL rnd_to i=%0d cycles=%0d err=%b ld=%h exp=%0d/1/0", i, o_req_cycles, o_err_done, o_ld, TO); end
         end else begin
            if (!wr) ld_model = m_load(f3, a, rdv);
            if (o_hung || o_mis !== 1'b0 || o_unstable || o_req_cycles != ack_at || o_err_done !== 1'b0 ||
                o_ld !== ld_model || o_addr !== (a & 32'hfffffffc) || o_we !== wr ||
                o_wstrb !== (wr ? m_wstrb(f3, a) : 4'b0000) || (wr && o_wdata !== m_wdata(f3, sd))) begin
               errors++; $display("FAIL rnd_acc i=%0d f3=%0d a=%h we=%b ld=%h/%h strb=%b/%b wd=%h/%h cyc=%0d/%0d",
                                   i, f3, a, o_we, o_ld, ld_model, o_wstrb, (wr ? m_wstrb(f3, a) : 4'b0000),
                                   o_wdata, m_wdata(f3, sd), o_req_cycles, ack_at); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_load_lanes();
      test_store();
      test_misaligned();
      test_timeout();
      test_reset_busy();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
